// File: rtl/sc_core_pkg.sv
// Shared types and memory-map constants for the single-cycle core's data-memory path.
// The region bounds are inclusive; everything outside them, including I_MEM, is unserved.
package sc_core_pkg;

  typedef enum logic [1:0] {
    REG_DMEM,
    REG_CR,
    REG_VGA,
    REG_NONE
  } t_mem_region;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } t_arb_state;

  localparam logic [31:0] D_MEM_REGION_FLOOR   = 32'h0001_0000;
  localparam logic [31:0] D_MEM_REGION_ROOF    = 32'h0001_FFFF;
  localparam logic [31:0] CR_REGION_FLOOR      = 32'h0002_0000;
  localparam logic [31:0] CR_REGION_ROOF       = 32'h0002_0FFF;
  localparam logic [31:0] VGA_MEM_REGION_FLOOR = 32'h00FF_0000;
  localparam logic [31:0] VGA_MEM_REGION_ROOF  = 32'h00FF_95FF;

endpackage

// File: rtl/sc_mem_region_dec.sv
// Combinational byte-address to target-region decoder.
// Any address outside the served windows decodes to REG_NONE.
module sc_mem_region_dec
  import sc_core_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  output t_mem_region       region_o
);

  // Widen so the compare works for any ADDR_W up to 64 bits.
  logic [63:0] addr_ext;
  assign addr_ext = 64'(addr_i);

  always_comb begin
    region_o = REG_NONE;
    if (addr_ext >= 64'(D_MEM_REGION_FLOOR) && addr_ext <= 64'(D_MEM_REGION_ROOF)) begin
      region_o = REG_DMEM;
    end else if (addr_ext >= 64'(CR_REGION_FLOOR) && addr_ext <= 64'(CR_REGION_ROOF)) begin
      region_o = REG_CR;
    end else if (addr_ext >= 64'(VGA_MEM_REGION_FLOOR) && addr_ext <= 64'(VGA_MEM_REGION_ROOF)) begin
      region_o = REG_VGA;
    end
  end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Two-requester arbiter in front of the shared data memory (core = 0, debug = 1).
// Define SC_DMEM_ARB_RR_EN for round-robin contention; otherwise requester 0 always wins.
module sc_dmem_arbiter
  import sc_core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [1:0]             ReqValid,
  input  logic [1:0][ADDR_W-1:0] ReqAddr,
  input  logic [1:0]             ReqWrEn,
  input  logic [1:0][3:0]        ReqByteEn,
  input  logic [1:0][DATA_W-1:0] ReqWrData,
  output logic [1:0]             ReqReady,
  output logic [1:0]             RspValid,
  output logic [1:0][DATA_W-1:0] RspData,
  output logic [1:0]             RspErr,
  output logic                   MemReq,
  output logic [ADDR_W-1:0]      MemAddr,
  output logic                   MemWrEn,
  output logic [3:0]             MemByteEn,
  output logic [DATA_W-1:0]      MemWrData,
  output t_mem_region            MemRegion,
  input  logic [DATA_W-1:0]      MemRdData,
  output t_arb_state             DbgState
);

  // Handshake: a request transfers on a rising edge where ReqValid[i] && ReqReady[i];
  // the requester holds its payload stable until then, and ReqReady never depends on
  // anything the requester drives other than ReqValid.

  t_arb_state          state_q, state_d;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wren_q;
  logic [3:0]          be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rsp_data_q;
  t_mem_region         region;
  logic                contend_winner;
  logic                grant;
  logic                hs;

`ifdef SC_DMEM_ARB_RR_EN
  logic last_q;

  assign contend_winner = ~last_q;

  // Pointer starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_q <= 1'b1;
    end else if (hs) begin
      last_q <= grant;
    end
  end
`else
  assign contend_winner = 1'b0;
`endif

  assign grant = (&ReqValid) ? contend_winner : ReqValid[1];

  always_comb begin
    ReqReady = '0;
    if (state_q == IDLE && !Rst && (|ReqValid)) begin
      ReqReady[grant] = 1'b1;
    end
  end

  assign hs = |(ReqValid & ReqReady);

  sc_mem_region_dec #(
    .ADDR_W(ADDR_W)
  ) u_dec (
    .addr_i  (addr_q),
    .region_o(region)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ISSUE;
      ISSUE:   state_d = (region != REG_NONE && !wren_q) ? WAIT : RESP;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wren_q     <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q    <= grant;
        addr_q     <= ReqAddr[grant];
        wren_q     <= ReqWrEn[grant];
        be_q       <= ReqByteEn[grant];
        wdata_q    <= ReqWrData[grant];
        rsp_data_q <= '0;
      end
      if (state_q == WAIT) begin
        rsp_data_q <= MemRdData;
      end
    end
  end

  // Writes and errors keep rsp_data_q at the zero loaded on handshake.
  always_comb begin
    MemReq    = 1'b0;
    MemAddr   = '0;
    MemWrEn   = 1'b0;
    MemByteEn = '0;
    MemWrData = '0;
    MemRegion = REG_DMEM;
    RspValid  = '0;
    RspData   = '0;
    RspErr    = '0;
    if (state_q == ISSUE) begin
      MemReq    = (region != REG_NONE);
      MemAddr   = addr_q;
      MemWrEn   = wren_q;
      MemByteEn = be_q;
      MemWrData = wdata_q;
      MemRegion = region;
    end
    if (state_q == RESP) begin
      RspValid[owner_q] = 1'b1;
      RspData[owner_q]  = rsp_data_q;
      RspErr[owner_q]   = (region == REG_NONE);
    end
  end

  assign DbgState = state_q;

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Self-checking bench for sc_dmem_arbiter: directed cases plus randomized traffic
// compared every cycle against a transaction-level model (age since acceptance).
module tb_sc_dmem_arbiter;
  import sc_core_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0][31:0]  req_addr;
  logic [1:0]        req_we;
  logic [1:0][3:0]   req_be;
  logic [1:0][31:0]  req_wd;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [1:0][31:0]  rsp_data;
  logic [1:0]        rsp_err;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wd;
  t_mem_region       mem_region;
  logic [31:0]       mem_rd_data;
  t_arb_state        dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  sc_dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk(clk), .Rst(rst), .ReqValid(req_valid), .ReqAddr(req_addr), .ReqWrEn(req_we),
    .ReqByteEn(req_be), .ReqWrData(req_wd), .ReqReady(req_ready), .RspValid(rsp_valid),
    .RspData(rsp_data), .RspErr(rsp_err), .MemReq(mem_req), .MemAddr(mem_addr),
    .MemWrEn(mem_we), .MemByteEn(mem_be), .MemWrData(mem_wd), .MemRegion(mem_region),
    .MemRdData(mem_rd_data), .DbgState(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int region_of(input logic [31:0] a);
    if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 0;
    if (a >= 32'h0002_0000 && a <= 32'h0002_0FFF) return 1;
    if (a >= 32'h00FF_0000 && a <= 32'h00FF_95FF) return 2;
    return 3;
  endfunction

  bit          m_active = 1'b0;
  int          m_age = 0;
  int          m_resp_age = 2;
  int          m_owner = 0;
  int          m_last = 1;
  int          m_region = 0;
  bit          m_rd_ok = 1'b0;
  logic [31:0] m_addr, m_wd, m_rdata;
  logic        m_we;
  logic [3:0]  m_be;
  bit          m_hs = 1'b0;
  int          m_hs_idx = 0;

  function automatic int winner();
    if (req_valid == 2'b11) begin
`ifdef SC_DMEM_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return req_valid[1] ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    m_hs = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_last   = 1;
    end else if (m_active) begin
      if (m_age == 2 && m_rd_ok) m_rdata = mem_rd_data;
      if (m_age == m_resp_age) m_active = 1'b0;
      else m_age++;
    end else if (|req_valid) begin
      m_hs_idx   = winner();
      m_hs       = 1'b1;
      m_active   = 1'b1;
      m_age      = 1;
      m_owner    = m_hs_idx;
      m_addr     = req_addr[m_hs_idx];
      m_we       = req_we[m_hs_idx];
      m_be       = req_be[m_hs_idx];
      m_wd       = req_wd[m_hs_idx];
      m_region   = region_of(m_addr);
      m_rd_ok    = !m_we && m_region != 3;
      m_resp_age = m_rd_ok ? 3 : 2;
      m_rdata    = '0;
      m_last     = m_hs_idx;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [1:0]       e_ready, e_rv, e_err;
    logic [1:0][31:0] e_rd;
    logic             e_mreq, e_mwe;
    logic [31:0]      e_maddr, e_mwd;
    logic [3:0]       e_mbe;
    int               e_region;
    if (cmp_en) begin
      e_ready = '0; e_rv = '0; e_err = '0; e_rd = '0;
      e_mreq = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_mwd = '0; e_mbe = '0; e_region = 0;
      if (!m_active && !rst && (|req_valid)) e_ready[winner()] = 1'b1;
      if (m_active && m_age == 1) begin
        e_mreq   = (m_region != 3);
        e_maddr  = m_addr;
        e_mwe    = m_we;
        e_mbe    = m_be;
        e_mwd    = m_wd;
        e_region = m_region;
      end
      if (m_active && m_age == m_resp_age) begin
        e_rv[m_owner]  = 1'b1;
        e_rd[m_owner]  = m_rd_ok ? m_rdata : 32'h0;
        e_err[m_owner] = (m_region == 3);
      end
      chk("req_ready", req_ready, e_ready);
      chk("mem_req", mem_req, e_mreq);
      chk("mem_addr", mem_addr, e_maddr);
      chk("mem_we", mem_we, e_mwe);
      chk("mem_be", mem_be, e_mbe);
      chk("mem_wd", mem_wd, e_mwd);
      chk("mem_region", 64'(mem_region), 64'(e_region));
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_data", rsp_data, e_rd);
      chk("rsp_err", rsp_err, e_err);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    mem_rd_data = $urandom;
  endtask

  function automatic logic [1:0] onehot(input int idx);
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic dir_write(input int idx, input logic [31:0] addr, input int exp_region,
                           input logic exp_err);
    req_valid[idx] = 1'b1;
    req_addr[idx]  = addr;
    req_we[idx]    = 1'b1;
    req_be[idx]    = 4'hF;
    req_wd[idx]    = $urandom;
    step();
    req_valid[idx] = 1'b0;
    @(negedge clk);
    chk("dir_memreq", mem_req, !exp_err);
    chk("dir_region", 64'(mem_region), 64'(exp_region));
    step();
    @(negedge clk);
    chk("dir_rspvalid", rsp_valid, onehot(idx));
    chk("dir_rsperr", rsp_err, exp_err ? onehot(idx) : 2'b00);
    chk("dir_rspdata", rsp_data, 64'h0);
    step();
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] bnd [10];
    bnd = '{32'h0000_0000, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_FFFF, 32'h0002_0000,
            32'h0002_0FFF, 32'h0002_1000, 32'h00FF_0000, 32'h00FF_95FF, 32'h00FF_9600};
    case ($urandom_range(0, 7))
      0, 1:    return 32'h0001_0000 + $urandom_range(0, 32'hFFFF);
      2:       return 32'h0002_0000 + $urandom_range(0, 32'hFFF);
      3:       return 32'h00FF_0000 + $urandom_range(0, 32'h95FF);
      4, 5:    return bnd[$urandom_range(0, 9)];
      6:       return $urandom_range(0, 32'hFFFF);
      default: return $urandom;
    endcase
  endfunction

  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    req_addr = {32'h0001_0004, 32'h0001_0008};
    req_we = 2'b00; req_be = '1; req_wd = '0;
    mem_rd_data = '0;

    // Reset: everything quiet even with both requesters asserting.
    step();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_memreq", mem_req, 1'b0);
    chk("rst_rspvalid", rsp_valid, 2'b00);
    chk("rst_region", 64'(mem_region), 64'h0);
    chk("rst_state_idle", dbg_state == IDLE, 1'b1);
    step();
    req_valid = 2'b00;
    rst = 1'b0;
    step();

    // Core read from DMEM, data returned at N+3.
    req_valid[0] = 1'b1; req_addr[0] = 32'h0001_0010; req_we[0] = 1'b0; req_be[0] = 4'hF;
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rd_memreq", mem_req, 1'b1);
    chk("rd_region", 64'(mem_region), 64'(REG_DMEM));
    chk("rd_memaddr", mem_addr, 32'h0001_0010);
    chk("rd_memwe", mem_we, 1'b0);
    step();
    mem_rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_wait_norsp", rsp_valid, 2'b00);
    step();
    @(negedge clk);
    chk("rd_rspvalid", rsp_valid, 2'b01);
    chk("rd_rspdata0", rsp_data[0], 32'hDEAD_BEEF);
    chk("rd_rsperr", rsp_err, 2'b00);
    step();
    @(negedge clk);
    chk("rd_done", rsp_valid, 2'b00);
    step();

    // Debug write to I_MEM space: error, no memory access.
    dir_write(1, 32'h0000_0100, 3, 1'b1);

    // Continuous contention.
`ifdef SC_DMEM_ARB_RR_EN
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_q = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    req_valid = 2'b11;
    req_we = 2'b11;
    req_addr = {32'h0001_0200, 32'h0001_0100};
    for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) got_q.push_back(req_ready);
      step();
    end
    req_valid = 2'b00;
    chk("grant_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("grant_order", (i < got_q.size()) ? got_q[i] : 2'bxx, exp_q[i]);
    end
    repeat (3) step();

    // Region boundaries.
    dir_write(0, 32'h00FF_95FF, 2, 1'b0);
    dir_write(0, 32'h00FF_9600, 3, 1'b1);
    dir_write(1, 32'h0001_FFFF, 0, 1'b0);
    dir_write(0, 32'h0002_0000, 1, 1'b0);
    dir_write(1, 32'h0002_0FFF, 1, 1'b0);
    dir_write(0, 32'h0002_1000, 3, 1'b1);
    dir_write(0, 32'h0000_FFFF, 3, 1'b1);
    dir_write(1, 32'h0001_0000, 0, 1'b0);

    // Reset during WAIT drops the read; a following read works.
    req_valid[0] = 1'b1; req_addr[0] = 32'h0001_0020; req_we[0] = 1'b0;
    step();
    req_valid[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_rspvalid", rsp_valid, 2'b00);
    chk("rstw_memreq", mem_req, 1'b0);
    chk("rstw_ready", req_ready, 2'b00);
    chk("rstw_state_idle", dbg_state == IDLE, 1'b1);
    step();
    @(negedge clk);
    chk("rstw_norsp", rsp_valid, 2'b00);
    req_valid[1] = 1'b1; req_addr[1] = 32'h00FF_0004; req_we[1] = 1'b0;
    step();
    req_valid[1] = 1'b0;
    step();
    mem_rd_data = 32'h1234_5678;
    step();
    @(negedge clk);
    chk("rstw_after_valid", rsp_valid, 2'b10);
    chk("rstw_after_data", rsp_data[1], 32'h1234_5678);
    step();
    step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 2; i++) begin
        if (m_hs && m_hs_idx == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i]  = rand_addr();
          req_we[i]    = 1'($urandom_range(0, 1));
          req_be[i]    = 4'($urandom);
          req_wd[i]    = $urandom;
        end
      end
      step();
    end
    rst = 1'b0;
    req_valid = 2'b00;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_dmem_arbiter.md
SC_DMEM_ARBITER -- requirements
Module: sc_dmem_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W, 32, address width; DATA_W, 32, data width.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, synchronous, active-high.
REQ-004 ReqValid  in  [1:0]  request valid; index 0 = core, index 1 = external/debug.
REQ-005 ReqAddr  in  [1:0][ADDR_W-1:0]  byte address per requester.
REQ-006 ReqWrEn  in  [1:0]  1 = write, 0 = read.
REQ-007 ReqByteEn  in  [1:0][3:0]  byte enables.
REQ-008 ReqWrData  in  [1:0][DATA_W-1:0]  write data.
REQ-009 ReqReady  out  [1:0]  request accepted when ReqValid[i]&&ReqReady[i].
REQ-010 RspValid  out  [1:0]  one-cycle response pulse to the owning requester.
REQ-011 RspData  out  [1:0][DATA_W-1:0]  read data; 0 for writes and errors.
REQ-012 RspErr  out  [1:0]  address decoded to no served region.
REQ-013 MemReq  out  1  shared memory access strobe.
REQ-014 MemAddr, MemWrEn, MemByteEn, MemWrData  out  ADDR_W/1/4/DATA_W  registered copy of the accepted request.
REQ-015 MemRegion  out  t_mem_region  target region select.
REQ-016 MemRdData  in  DATA_W  valid exactly one cycle after MemReq with MemWrEn=0.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-018 ReqReady SHALL be asserted only in IDLE, only to the arbitration winner, and only while that requester's ReqValid is high (combinational).
REQ-019 Handshake at edge N SHALL latch the payload and owner index, and the FSM SHALL go to ISSUE.
REQ-020 In ISSUE (N+1), Mem* SHALL be driven from the latched payload, and MemReq SHALL be 1 only if the region is valid.
REQ-021 ISSUE SHALL go to WAIT for a valid read, else to RESP.
REQ-022 WAIT SHALL capture MemRdData into the response register, then go to RESP.
REQ-023 RESP SHALL pulse RspValid[owner] for exactly one cycle, then return to IDLE.
REQ-024 Latency: read RspValid at N+3; write ack at N+2; error at N+2 with RspErr=1 and no MemReq.
REQ-025 Region decode (inclusive ranges):
  - DMEM: 0x0001_0000-0x0001_FFFF
  - CR: 0x0002_0000-0x0002_0FFF
  - VGA: 0x00FF_0000-0x00FF_95FF
  - All other addresses, including I_MEM 0x0-0xFFFF, are errors.
REQ-026 Simultaneous valid requests in IDLE SHALL be resolved per REQ-031/032; a lone request SHALL be granted regardless of priority.
REQ-027 ReqValid changes outside IDLE SHALL be ignored, and requesters SHALL hold their payload until Ready.
REQ-028 Outside ISSUE, all Mem* outputs SHALL be 0.

Reset
REQ-029 Rst SHALL force IDLE on the next edge from any state; the outstanding transaction is dropped with no RspValid.
REQ-030 Reset values SHALL be: all outputs 0; MemRegion = REG_DMEM (encoded 0); RR pointer = last-granted 1, so requester 0 wins the first contention.

Configuration
REQ-031 With SC_DMEM_ARB_RR_EN defined, contention SHALL be round-robin: the requester not granted last wins, and the pointer updates only on handshake.
REQ-032 Without SC_DMEM_ARB_RR_EN, requester 0 SHALL always win contention, and no pointer flop SHALL exist.

Structure
REQ-033 sc_core_pkg SHALL hold:
  - typedef enum logic[1:0] t_mem_region {REG_DMEM, REG_CR, REG_VGA, REG_NONE}
  - CR_REGION_FLOOR/ROOF
  - existing VGA_MEM_REGION_FLOOR/ROOF, D_MEM_REGION_FLOOR/ROOF
  - t_arb_state enum
REQ-034 Decode SHALL be a combinational sub-module sc_mem_region_dec (address in, t_mem_region out), instantiated once on the latched address.

Verification
REQ-035 Req0 read 0x0001_0010, MemRdData=0xDEADBEEF at N+2 -> MemReq/REG_DMEM at N+1; Rsp0 data 0xDEADBEEF, Err=0 at N+3.
REQ-036 Both valid continuously, with RR_EN -> grants 0,1,0,1; without -> grants 0,0,0, Req1 never Ready.
REQ-037 Req1 write 0x0000_0100 -> no MemReq; RspValid[1]=1, RspErr=1 at N+2.
REQ-038 Write 0x00FF_95FF -> REG_VGA, MemReq=1; write 0x00FF_9600 -> RspErr=1; 0x0001_FFFF -> REG_DMEM; 0x0002_0000 -> REG_CR.
REQ-039 Rst asserted during WAIT -> IDLE next cycle, all outputs 0, no RspValid; a following request is served normally.
